// File: rtl/proc_perf_pkg.sv
// proc_perf_pkg
//   Shared definitions for the processor performance-counter block:
//   the control FSM state encoding, the counter index map used both for
//   the increment vector and the read-select port, and the counter count.
package proc_perf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } perf_state_t;

    localparam int NUM_CNT = 7;

    // Counter index map; also the rd_sel encoding.
    localparam int CYC   = 0;
    localparam int INST  = 1;
    localparam int IREQ  = 2;
    localparam int IHIT  = 3;
    localparam int DREQ  = 4;
    localparam int DHIT  = 5;
    localparam int STALL = 6;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter with a sticky overflow flag. The count stops at
//   all-ones; an increment request while already at all-ones sets ovf,
//   which stays set until clr or rst.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset (clears cnt and ovf)
//   clr  - synchronous clear of cnt and ovf, wins over inc
//   inc  - increment request for this cycle
//   cnt  - current count
//   ovf  - sticky saturation flag
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic atMax;

    assign atMax = &cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (atMax) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/proc_perf_counters.sv
// proc_perf_counters
//   Performance counters fed by the pipeline's per-cycle commit, cache and
//   stall strobes. A small FSM (IDLE -> RUN -> HALTED) gates counting:
//   counters advance only while the registered state is RUN, which includes
//   the cycle in which halt is sampled. clr returns to IDLE from any state
//   and zeroes counters and overflow flags. There is no valid/ready
//   handshake: every input is a single-cycle strobe sampled on each edge.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   start        - leave IDLE and begin counting (ignored elsewhere)
//   clr          - synchronous clear, forces IDLE, highest priority
//   reg_write    - register file written this cycle
//   mem_write    - data memory written this cycle
//   halt         - halt at MEM/WB; RUN -> HALTED
//   stall        - pipeline stalled this cycle
//   icache_req/icache_hit, dcache_req/dcache_hit - cache strobes
//   rd_sel       - counter select (indices in proc_perf_pkg; 7 reads 0)
//   rd_data      - registered value of the selected counter
//   ovf          - sticky per-counter saturation flags
//   running      - state is RUN
//   halted       - state is HALTED
//   dbgState     - registered FSM state for observation
module proc_perf_counters
    import proc_perf_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               clr,
    input  logic               reg_write,
    input  logic               mem_write,
    input  logic               halt,
    input  logic               stall,
    input  logic               icache_req,
    input  logic               icache_hit,
    input  logic               dcache_req,
    input  logic               dcache_hit,
    input  logic [2:0]         rd_sel,
    output logic [CNT_W-1:0]   rd_data,
    output logic [NUM_CNT-1:0] ovf,
    output logic               running,
    output logic               halted,
    output perf_state_t        dbgState
);

    perf_state_t stateQ;
    perf_state_t stateD;

    logic [NUM_CNT-1:0] incVec;
    logic [CNT_W-1:0]   cntArr [NUM_CNT];
    logic [CNT_W-1:0]   rdNext;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic; clr overrides both start and halt.
    always_comb begin
        stateD = stateQ;
        if (clr) begin
            stateD = IDLE;
        end else begin
            case (stateQ)
                IDLE:    if (start) stateD = RUN;
                RUN:     if (halt)  stateD = HALTED;
                HALTED:  stateD = HALTED;
                default: stateD = IDLE;
            endcase
        end
    end

    assign running  = (stateQ == RUN);
    assign halted   = (stateQ == HALTED);
    assign dbgState = stateQ;

    // Increment decode. Hits only count alongside their request, and an
    // instruction counts once even if several commit strobes coincide.
    always_comb begin
        incVec = '0;
        if (running && !clr) begin
            incVec[CYC]   = 1'b1;
            incVec[INST]  = halt | reg_write | mem_write;
            incVec[IREQ]  = icache_req;
            incVec[IHIT]  = icache_req & icache_hit;
            incVec[DREQ]  = dcache_req;
            incVec[DHIT]  = dcache_req & dcache_hit;
            incVec[STALL] = stall;
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : gCnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) uCnt (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .inc (incVec[g]),
            .cnt (cntArr[g]),
            .ovf (ovf[g])
        );
    end

    // Read mux; unmapped selects fall through to zero.
    always_comb begin
        rdNext = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_sel == 3'(i)) begin
                rdNext = cntArr[i];
            end
        end
    end

    // Registered read: shows counter values from before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rdNext;
        end
    end

endmodule

// File: tb/tb_proc_perf_counters.sv
// tb_proc_perf_counters
//   Directed bench for proc_perf_counters. Two instances share the same
//   stimulus: a 32-bit one for the general behaviour and a 4-bit one to
//   reach saturation quickly.
module tb_proc_perf_counters;
    import proc_perf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic clr = 1'b0;
    logic reg_write = 1'b0;
    logic mem_write = 1'b0;
    logic halt = 1'b0;
    logic stall = 1'b0;
    logic icache_req = 1'b0;
    logic icache_hit = 1'b0;
    logic dcache_req = 1'b0;
    logic dcache_hit = 1'b0;
    logic [2:0] rd_sel = 3'd0;

    logic [31:0] rdData32;
    logic [6:0]  ovf32;
    logic        running32, halted32;
    perf_state_t dbgState32;

    logic [3:0]  rdData4;
    logic [6:0]  ovf4;
    logic        running4, halted4;
    perf_state_t dbgState4;

    int numVectors = 0;
    int numMiscompares = 0;

    proc_perf_counters #(.CNT_W(32)) dut32 (
        .clk(clk), .rst(rst), .start(start), .clr(clr),
        .reg_write(reg_write), .mem_write(mem_write), .halt(halt), .stall(stall),
        .icache_req(icache_req), .icache_hit(icache_hit),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit),
        .rd_sel(rd_sel), .rd_data(rdData32), .ovf(ovf32),
        .running(running32), .halted(halted32), .dbgState(dbgState32)
    );

    proc_perf_counters #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .clr(clr),
        .reg_write(reg_write), .mem_write(mem_write), .halt(halt), .stall(stall),
        .icache_req(icache_req), .icache_hit(icache_hit),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit),
        .rd_sel(rd_sel), .rd_data(rdData4), .ovf(ovf4),
        .running(running4), .halted(halted4), .dbgState(dbgState4)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        numVectors++;
        if (got !== exp) begin
            numMiscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Event bits: {halt, reg_write, mem_write, stall, ireq, ihit, dreq, dhit}.
    task automatic step(input logic [7:0] ev);
        {halt, reg_write, mem_write, stall,
         icache_req, icache_hit, dcache_req, dcache_hit} = ev;
        tick();
        {halt, reg_write, mem_write, stall,
         icache_req, icache_hit, dcache_req, dcache_hit} = '0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulseClr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Registered read of both instances; counters must be idle here.
    task automatic readCnt(input int sel, output logic [31:0] v32, output logic [3:0] v4);
        rd_sel = 3'(sel);
        tick();
        v32 = rdData32;
        v4  = rdData4;
    endtask

    localparam logic [7:0] EV_HALT = 8'b1000_0000;
    localparam logic [7:0] EV_RW   = 8'b0100_0000;
    localparam logic [7:0] EV_MW   = 8'b0010_0000;
    localparam logic [7:0] EV_STL  = 8'b0001_0000;
    localparam logic [7:0] EV_IREQ = 8'b0000_1000;
    localparam logic [7:0] EV_IHIT = 8'b0000_0100;
    localparam logic [7:0] EV_DREQ = 8'b0000_0010;
    localparam logic [7:0] EV_DHIT = 8'b0000_0001;

    initial begin
        logic [31:0] v32;
        logic [3:0]  v4;
        logic [31:0] expSweep [8];

        // Reset state.
        #2;
        checkVal("rst_rd_data", 64'(rdData32), 64'd0);
        checkVal("rst_ovf", 64'(ovf32), 64'd0);
        checkVal("rst_running", 64'(running32), 64'd0);
        checkVal("rst_halted", 64'(halted32), 64'd0);
        checkVal("rst_state", 64'(dbgState32), 64'(IDLE));
        tick();
        rst = 1'b0;
        tick();

        // Ten RUN cycles, four with reg_write, then halt.
        pulseStart();
        checkVal("t1_running", 64'(running32), 64'd1);
        for (int i = 0; i < 10; i++) step((i % 3 == 0) ? EV_RW : 8'h00);
        step(EV_HALT);
        checkVal("t1_halted", 64'(halted32), 64'd1);
        checkVal("t1_running_off", 64'(running32), 64'd0);
        for (int i = 0; i < 5; i++) step(EV_RW | EV_STL);
        pulseStart();
        checkVal("t1_start_ignored", 64'(halted32), 64'd1);
        readCnt(CYC, v32, v4);
        checkVal("t1_cyc", 64'(v32), 64'd11);
        readCnt(INST, v32, v4);
        checkVal("t1_inst", 64'(v32), 64'd5);
        readCnt(STALL, v32, v4);
        checkVal("t1_stall_frozen", 64'(v32), 64'd0);

        // Hit without request is ignored.
        pulseClr();
        checkVal("t2_clr_idle", 64'(dbgState32), 64'(IDLE));
        pulseStart();
        for (int i = 0; i < 3; i++) step(EV_IHIT);
        for (int i = 0; i < 2; i++) step(EV_IREQ | EV_IHIT);
        step(EV_HALT);
        readCnt(IREQ, v32, v4);
        checkVal("t2_ireq", 64'(v32), 64'd2);
        readCnt(IHIT, v32, v4);
        checkVal("t2_ihit", 64'(v32), 64'd2);
        readCnt(CYC, v32, v4);
        checkVal("t2_cyc", 64'(v32), 64'd6);

        // Saturation on the 4-bit instance.
        pulseClr();
        pulseStart();
        for (int i = 0; i < 20; i++) step(EV_STL);
        step(EV_HALT);
        readCnt(STALL, v32, v4);
        checkVal("t3_stall4", 64'(v4), 64'd15);
        checkVal("t3_stall32", 64'(v32), 64'd20);
        readCnt(CYC, v32, v4);
        checkVal("t3_cyc4", 64'(v4), 64'd15);
        checkVal("t3_cyc32", 64'(v32), 64'd21);
        checkVal("t3_ovf4", 64'(ovf4), 64'b100_0001);
        checkVal("t3_ovf32", 64'(ovf32), 64'd0);
        pulseClr();
        checkVal("t3_ovf4_clr", 64'(ovf4), 64'd0);

        // clr and halt together in RUN.
        pulseStart();
        step(EV_RW);
        step(EV_STL);
        clr = 1'b1;
        step(EV_HALT);
        clr = 1'b0;
        checkVal("t4_state", 64'(dbgState32), 64'(IDLE));
        checkVal("t4_halted", 64'(halted32), 64'd0);
        checkVal("t4_running", 64'(running32), 64'd0);
        for (int s = 0; s < NUM_CNT; s++) begin
            readCnt(s, v32, v4);
            checkVal($sformatf("t4_cnt%0d", s), 64'(v32), 64'd0);
        end

        // Asynchronous reset mid-run.
        rd_sel = 3'(CYC);
        pulseStart();
        for (int i = 0; i < 7; i++) step(8'h00);
        checkVal("t5_cyc_pre", 64'(rdData32), 64'd6);
        rst = 1'b1;
        #2;
        checkVal("t5_rst_rd_data", 64'(rdData32), 64'd0);
        checkVal("t5_rst_running", 64'(running32), 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(EV_RW | EV_STL);
        checkVal("t5_no_run", 64'(running32), 64'd0);
        readCnt(CYC, v32, v4);
        checkVal("t5_cyc_held", 64'(v32), 64'd0);
        pulseStart();
        for (int i = 0; i < 3; i++) step(8'h00);
        step(EV_HALT);
        readCnt(CYC, v32, v4);
        checkVal("t5_cyc_restart", 64'(v32), 64'd4);

        // Known mixed run, then sweep every select.
        pulseClr();
        pulseStart();
        step(EV_RW | EV_IREQ | EV_IHIT);
        step(EV_MW | EV_IREQ | EV_DREQ);
        step(EV_STL);
        step(EV_RW | EV_MW | EV_IREQ | EV_IHIT | EV_DREQ | EV_DHIT);
        step(EV_STL | EV_DHIT);
        step(EV_HALT | EV_IREQ);
        expSweep[0] = 32'd6;
        expSweep[1] = 32'd4;
        expSweep[2] = 32'd4;
        expSweep[3] = 32'd2;
        expSweep[4] = 32'd2;
        expSweep[5] = 32'd1;
        expSweep[6] = 32'd2;
        expSweep[7] = 32'd0;
        for (int s = 0; s < 8; s++) begin
            readCnt(s, v32, v4);
            checkVal($sformatf("t6_sel%0d", s), 64'(v32), 64'(expSweep[s]));
        end
        checkVal("t6_ovf", 64'(ovf32), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule
